// File: rtl/div_bcd_formatter_if.sv
// -----------------------------------------------------------------------------
// div_bcd_formatter_if
// Bundles the result handshake between the long-division controller and the
// BCD formatter, along with the formatter's display-facing outputs.
//   div_done   : one-cycle pulse, quotient/remainder valid
//   div_error  : one-cycle pulse, divide by zero
//   quotient   : unsigned quotient (SIZE bits)
//   remainder  : unsigned remainder (SIZE bits)
//   busy       : formatter is not idle
//   bcd_valid  : one-cycle pulse, q_bcd/r_bcd hold a new result
//   err_flag   : sticky divide-by-zero indication
//   q_bcd      : packed BCD quotient, digit 0 in [3:0]
//   r_bcd      : packed BCD remainder, digit 0 in [3:0]
// Modports: master = divider/display side, slave = formatter.
// -----------------------------------------------------------------------------
interface div_bcd_formatter_if #(
    parameter int SIZE   = 8,
    parameter int DIGITS = 3
);
    logic                  div_done;
    logic                  div_error;
    logic [SIZE-1:0]       quotient;
    logic [SIZE-1:0]       remainder;
    logic                  busy;
    logic                  bcd_valid;
    logic                  err_flag;
    logic [4*DIGITS-1:0]   q_bcd;
    logic [4*DIGITS-1:0]   r_bcd;

    modport master (
        output div_done, div_error, quotient, remainder,
        input  busy, bcd_valid, err_flag, q_bcd, r_bcd
    );

    modport slave (
        input  div_done, div_error, quotient, remainder,
        output busy, bcd_valid, err_flag, q_bcd, r_bcd
    );
endinterface

// File: rtl/div_bcd_formatter.sv
// -----------------------------------------------------------------------------
// div_bcd_formatter
// Captures the divider's quotient and remainder on div_done and converts both
// to packed BCD with a sequential double-dabble (one bit per clock). A
// divide-by-zero pulse clears the displayed values and raises a sticky flag
// that is cleared by the next successful conversion.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; returns to IDLE and clears all state
//   bus   : div_bcd_formatter_if.slave (handshake inputs, BCD/status outputs)
// -----------------------------------------------------------------------------
module div_bcd_formatter #(
    parameter int SIZE   = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    div_bcd_formatter_if.slave bus
);

    localparam int W  = 4 * DIGITS;       // BCD accumulator width
    localparam int SW = W + SIZE;         // {accumulator, binary} shift width
    localparam int CW = $clog2(SIZE + 1); // shift counter width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [SW-1:0]   q_sr_r;       // quotient: {BCD accumulator, binary}
    logic [SW-1:0]   r_sr_r;       // remainder: {BCD accumulator, binary}
    logic [SW-1:0]   q_step_s;
    logic [SW-1:0]   r_step_s;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    q_bcd_r;
    logic [W-1:0]    r_bcd_r;
    logic            err_r;
    logic            busy_r;
    logic            valid_r;

    // Add 3 to every BCD digit that is 5 or more; digits never carry into
    // each other because a digit of at most 9 becomes at most 12.
    function automatic logic [W-1:0] add3_digits(input logic [W-1:0] acc);
        logic [W-1:0] res;
        logic [3:0]   d;
        res = {W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            d = acc[4*i +: 4];
            if (d >= 4'd5) begin
                res[4*i +: 4] = d + 4'd3;
            end else begin
                res[4*i +: 4] = d;
            end
        end
        return res;
    endfunction

    // One double-dabble step for both values: adjust digits, then shift left
    // so the binary MSB enters accumulator bit 0.
    always_comb begin
        q_step_s = {add3_digits(q_sr_r[SW-1:SIZE]), q_sr_r[SIZE-1:0]} << 1'b1;
        r_step_s = {add3_digits(r_sr_r[SW-1:SIZE]), r_sr_r[SIZE-1:0]} << 1'b1;
    end

    // Next-state logic; an error pulse in IDLE takes priority over div_done.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.div_error) begin
                    state_nx_s = IDLE;
                end else if (bus.div_done) begin
                    state_nx_s = CONVERT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CONVERT: begin
                if (cnt_r == CW'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CONVERT;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Status outputs registered from the next state so they track the state
    // register exactly, without a decode path on the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r  <= (state_nx_s != IDLE);
            valid_r <= (state_nx_s == DONE);
        end
    end

    // Capture, conversion datapath and result/flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_sr_r  <= {SW{1'b0}};
            r_sr_r  <= {SW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            q_bcd_r <= {W{1'b0}};
            r_bcd_r <= {W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.div_error) begin
                        err_r   <= 1'b1;
                        q_bcd_r <= {W{1'b0}};
                        r_bcd_r <= {W{1'b0}};
                    end else if (bus.div_done) begin
                        q_sr_r <= {{W{1'b0}}, bus.quotient};
                        r_sr_r <= {{W{1'b0}}, bus.remainder};
                        cnt_r  <= CW'(SIZE);
                    end
                end
                CONVERT: begin
                    q_sr_r <= q_step_s;
                    r_sr_r <= r_step_s;
                    cnt_r  <= cnt_r - CW'(1);
                    // Last shift: publish the post-shift accumulators.
                    if (cnt_r == CW'(1)) begin
                        q_bcd_r <= q_step_s[SW-1:SIZE];
                        r_bcd_r <= r_step_s[SW-1:SIZE];
                        err_r   <= 1'b0;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.bcd_valid = valid_r;
    assign bus.err_flag  = err_r;
    assign bus.q_bcd     = q_bcd_r;
    assign bus.r_bcd     = r_bcd_r;

endmodule
